// File: rtl/matrix_feeder.sv
// matrix_feeder: buffers one A/B operand pair and
// replays it as a start-pulse-then-stream sequence.
module matrix_feeder #(
   parameter int DW = 8,
   parameter int M  = 8,
   parameter int N  = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [DW-1:0] load_data,
   input  logic          send,
   output logic          full,
   output logic          busy,
   output logic          start,
   output logic [DW-1:0] data_out,
   output logic          data_valid,
   output logic          sent_done
);

   localparam int L  = 2 * M * N;
   localparam int CW = $clog2(L + 1);
   localparam int IW = (L > 1) ? $clog2(L) : 1;

   localparam logic [CW-1:0] CNT_FULL = CW'(L);
   localparam logic [IW-1:0] IDX_LAST = IW'(L - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      GAP,
      STREAM,
      FINISH
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   wr_cnt;
   logic [IW-1:0]   rd_idx;
   logic [IW-1:0]   rd_nx;
   logic [DW-1:0]   mem [L];
   logic [DW-1:0]   data_q;
   logic            wr_ok;

   assign full  = (wr_cnt == CNT_FULL);
   assign wr_ok = (state == IDLE) && load_en && !full;

   // Next state and next read index.
   always_comb begin
      state_nx = state;
      rd_nx    = rd_idx;
      unique case (state)
         IDLE: begin
            if (send && full)
               state_nx = START;
         end
         START: state_nx = GAP;
         GAP: begin
            state_nx = STREAM;
            rd_nx    = '0;
         end
         STREAM: begin
            if (rd_idx == IDX_LAST) begin
               state_nx = FINISH;
               rd_nx    = '0;
            end else begin
               rd_nx = rd_idx + IW'(1);
            end
         end
         FINISH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State and read index registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         rd_idx <= '0;
      end else begin
         state  <= state_nx;
         rd_idx <= rd_nx;
      end
   end

   // Write count: saturates at L, emptied when FINISH ends.
   always_ff @(posedge clk) begin
      if (reset)
         wr_cnt <= '0;
      else if (state == FINISH)
         wr_cnt <= '0;
      else if (wr_ok)
         wr_cnt <= wr_cnt + CW'(1);
   end

   // Buffer RAM; contents survive reset and FINISH.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_cnt[IW-1:0]] <= load_data;
   end

   // Registered stream data, zero outside STREAM.
   always_ff @(posedge clk) begin
      if (reset)
         data_q <= '0;
      else if (state_nx == STREAM)
         data_q <= mem[rd_nx];
      else
         data_q <= '0;
   end

   assign busy       = (state != IDLE);
   assign start      = (state == START);
   assign data_valid = (state == STREAM);
   assign sent_done  = (state == FINISH);
   assign data_out   = data_q;

endmodule

// File: tb/tb_matrix_feeder.sv
// tb_matrix_feeder: directed stimulus with a
// queue scoreboard checked by a stream monitor.
module tb_matrix_feeder;

   localparam int DW = 8;
   localparam int M  = 2;
   localparam int N  = 2;
   localparam int L  = 2 * M * N;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load_en = 1'b0;
   logic [DW-1:0] load_data = '0;
   logic          send = 1'b0;
   logic          full;
   logic          busy;
   logic          start;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          sent_done;

   logic [DW-1:0] exp_q [$];
   int            vecs = 0;
   int            errs = 0;
   int            done_exp = 0;
   int            done_seen = 0;

   matrix_feeder #(
      .DW(DW),
      .M (M),
      .N (N)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load_en   (load_en),
      .load_data (load_data),
      .send      (send),
      .full      (full),
      .busy      (busy),
      .start     (start),
      .data_out  (data_out),
      .data_valid(data_valid),
      .sent_done (sent_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input int act,
                      input int exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d",
                  nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream monitor: pops one expected element per valid beat.
   always @(negedge clk) begin
      if (data_valid) begin
         if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL stream: got %0d, expected none",
                     data_out);
         end else begin
            chk("stream", int'(data_out),
                int'(exp_q.pop_front()));
         end
      end
      if (sent_done)
         done_seen++;
   end

   task automatic load(input int v);
      load_en   = 1'b1;
      load_data = DW'(v);
      tick();
      load_en = 1'b0;
   endtask

   task automatic load_seq(input int n);
      for (int i = 1; i <= n; i++)
         load(i);
   endtask

   task automatic send_stream(input bit ld_mid);
      for (int i = 1; i <= L; i++)
         exp_q.push_back(DW'(i));
      done_exp++;
      send = 1'b1;
      tick();
      send = 1'b0;
      chk("start_e0", int'(start), 1);
      chk("busy_e0", int'(busy), 1);
      tick();
      chk("start_gap", int'(start), 0);
      chk("valid_gap", int'(data_valid), 0);
      for (int k = 0; k < L; k++) begin
         if (ld_mid && k == 3) begin
            load_en   = 1'b1;
            load_data = 8'd55;
         end
         tick();
         load_en = 1'b0;
         chk("valid_stream", int'(data_valid), 1);
      end
      tick();
      chk("done_pulse", int'(sent_done), 1);
      chk("valid_finish", int'(data_valid), 0);
      chk("dout_finish", int'(data_out), 0);
      chk("full_finish", int'(full), 1);
      tick();
      chk("busy_after", int'(busy), 0);
      chk("full_after", int'(full), 0);
      chk("done_after", int'(sent_done), 0);
   endtask

   initial begin
      // reset state
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_full", int'(full), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_start", int'(start), 0);
      chk("rst_dout", int'(data_out), 0);
      chk("rst_valid", int'(data_valid), 0);
      chk("rst_done", int'(sent_done), 0);

      // basic load and send
      load_seq(L - 1);
      chk("full_l7", int'(full), 0);
      load(L);
      chk("full_l8", int'(full), 1);
      send_stream(1'b0);

      // overfill is dropped
      load_seq(L);
      load(99);
      chk("full_over", int'(full), 1);
      chk("busy_over", int'(busy), 0);
      send_stream(1'b0);

      // early send ignored
      load_seq(5);
      send = 1'b1;
      tick();
      send = 1'b0;
      chk("early_busy", int'(busy), 0);
      chk("early_start", int'(start), 0);
      tick();
      chk("early_busy2", int'(busy), 0);
      load(6);
      load(7);
      chk("early_full7", int'(full), 0);
      load(8);
      chk("early_full8", int'(full), 1);
      send_stream(1'b0);

      // load during stream has no effect
      load_seq(L);
      send_stream(1'b1);
      load_seq(L - 1);
      chk("mid_full7", int'(full), 0);
      load(L);
      chk("mid_full8", int'(full), 1);
      send_stream(1'b0);

      // reset mid-stream
      load_seq(L);
      for (int i = 1; i <= 4; i++)
         exp_q.push_back(DW'(i));
      send = 1'b1;
      tick();
      send = 1'b0;
      tick();
      for (int k = 0; k < 4; k++)
         tick();
      chk("mrst_dout4", int'(data_out), 4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_valid", int'(data_valid), 0);
      chk("mrst_dout", int'(data_out), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_full", int'(full), 0);
      chk("mrst_done", int'(sent_done), 0);
      chk("mrst_q", exp_q.size(), 0);
      for (int k = 0; k < L + 2; k++) begin
         tick();
         chk("mrst_idle", int'(busy), 0);
      end

      // same-edge load and send at L-1
      load_seq(L - 1);
      load_en   = 1'b1;
      load_data = 8'd8;
      send      = 1'b1;
      tick();
      load_en = 1'b0;
      send    = 1'b0;
      chk("same_full", int'(full), 1);
      chk("same_start", int'(start), 0);
      chk("same_busy", int'(busy), 0);
      tick();
      chk("same_start2", int'(start), 0);
      send_stream(1'b0);

      tick();
      tick();
      chk("q_empty", exp_q.size(), 0);
      chk("done_count", done_seen, done_exp);

      $display("== %0d vectors applied, %0d miscompares ==",
               vecs, errs);
      $finish;
   end

endmodule

// File: doc/matrix_feeder.md
# matrix_feeder

Stream source for the `matrix_mult` serial input port. The block buffers one operand pair, A followed by B, written element by element from a host-side load interface. On command it replays the pair to `matrix_mult` using the same start-pulse-then-stream sequence `matrix_mult` expects. It sits directly in front of `matrix_mult`: its `start` and `data_out` connect to that block's `start` and `data_in`, and its parameters match.

## Interface
- `DW`, default 8: element width in bits.
- `M`, default 8: rows of A.
- `N`, default 8: columns of A. Total stream length is `L = 2*M*N` elements (A then B, row-major).
- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `load_en`  in  1: write strobe for `load_data`.
- `load_data`  in  DW: element to append to the buffer.
- `send`  in  1: request to transmit the buffered pair.
- `full`  out  1: buffer holds L elements.
- `busy`  out  1: transmission in progress (any state other than IDLE).
- `start`  out  1: one-cycle start pulse to `matrix_mult`.
- `data_out`  out  DW: element stream to `matrix_mult` `data_in`.
- `data_valid`  out  1: `data_out` carries a stream element this cycle.
- `sent_done`  out  1: one-cycle pulse after the last element.

## Operation
- Buffer: L x DW storage, written at index `wr_cnt`. `wr_cnt` is `$clog2(L+1)` bits wide and saturates at L. `full = (wr_cnt == L)`.
- Load: in IDLE with `load_en=1` and `!full`, write `load_data` to `buf[wr_cnt]` and increment `wr_cnt`.
  - `load_en` is ignored when full or when not in IDLE. No error flag is raised.
- FSM states and transitions:
  - IDLE -> START when `send=1 && full`. `send` is ignored when not full.
  - START: `start=1` for exactly one cycle, then -> GAP.
  - GAP: one idle cycle (`start=0`, `data_valid=0`), then -> STREAM with `rd_idx=0`.
  - STREAM: `data_out=buf[rd_idx]` and `data_valid=1`. `rd_idx` increments each cycle. After the cycle with `rd_idx=L-1`, -> FINISH.
  - FINISH: `sent_done=1` for one cycle. `wr_cnt` is cleared to 0. Buffer contents are retained but count as empty. Then -> IDLE.
- `data_out` is registered and reads 0 in every state other than STREAM.
- Simultaneous events:
  - `load_en` and `send` in the same IDLE cycle with `wr_cnt=L-1`: the write completes and `send` is ignored, because the buffer was not full at that edge.
  - Both asserted while full: `send` wins and the write is dropped.
- `send` held high is harmless. It is sampled only in IDLE, so holding it through FINISH starts a new send only after the buffer is reloaded to full.
- Reset, including mid-stream: state <- IDLE, `wr_cnt` <- 0, `rd_idx` <- 0. All outputs take their reset values on the same edge. Buffer RAM contents are not cleared.

## Timing
- Reset values: `full=0`, `busy=0`, `start=0`, `data_out=0`, `data_valid=0`, `sent_done=0`.
- All outputs are registered, i.e. they update on the edge that enters the corresponding state.
- With `send` sampled high at edge E0:
  - `start=1` during cycle E0..E1.
  - GAP during E1..E2.
  - Element k is on `data_out` during E(2+k)..E(3+k), for k = 0..L-1.
  - `sent_done=1` during E(2+L)..E(3+L).
  - `busy=0` from E(3+L).
- Total busy time is L+3 cycles.
- `full` drops at edge E(3+L), the edge that leaves FINISH.
- The earliest next `send` requires L more loads, so there is no back-to-back send.

## Test plan
- Reset, then check outputs and load/send handling. With DW=8, M=2, N=2 (L=8):
  - After reset, all outputs are 0.
  - Load 1..8 on consecutive cycles; `full` rises after the 8th write.
  - Pulse `send` at edge E0: `start` is high for exactly one cycle; `data_out` reads 1,2,...,8 with `data_valid=1` on cycles E2..E9; `sent_done` pulses at E10.
- Overfill: write a 9th element (value 99) while full, then send. The stream is still 1..8 and 99 never appears.
- Early send: pulse `send` after only 5 loads. Required: `busy` stays 0, `start` stays 0, and `wr_cnt` is unchanged. Then complete the loads; `send` now transmits normally.
- Load during stream: assert `load_en` with value 55 during STREAM. Required: no effect on the current stream, and `wr_cnt=0` after FINISH.
- Reset mid-stream: assert `reset` one cycle while `data_out=4`. Required: on the next edge `data_valid=0`, `data_out=0`, `busy=0`, `full=0`, and no `sent_done` pulse.
- Same-edge load and send: set `load_en=1` with `load_data=8` and `send=1` together at `wr_cnt=7`. Required: `full` rises and no `start` occurs. A later `send` streams 1..8.
